shiftsub_div: RTL and testbench

- Sequential restoring (shift-and-subtract) divider; the inverse operation of the team's shift-and-add multiplier.
- Divides a 2n-bit dividend by an n-bit divisor and produces an n-bit quotient and an n-bit remainder.
- Retires one quotient bit per clock.
- Sits on the same start/stop handshake as the multiplier, so a datapath controller can chain multiply then divide, e.g. for scaling.

---
 rtl/shiftsub_div_pkg.sv | 21 ++
 rtl/shiftsub_div_if.sv | 26 ++
 rtl/shiftsub_div_step.sv | 28 ++
 rtl/shiftsub_div.sv | 124 ++++++++++++
 tb/tb_shiftsub_div.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/shiftsub_div_pkg.sv
// Shared definitions for the shift-based arithmetic blocks (multiplier and divider).
package shiftsub_div_pkg;

  // Control states shared by the multiplier and the divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width.
  localparam int N_DEF = 8;

  // The step counter must hold values 0..n.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/shiftsub_div_if.sv
// Start/stop handshake and operand/result bus for the shift-based divider.
interface shiftsub_div_if
  import shiftsub_div_pkg::*;
#(
  parameter int n = N_DEF
);

  logic           start;
  logic [2*n-1:0] i_A;
  logic [n-1:0]   i_B;
  logic           stop;
  logic           err;
  logic [n-1:0]   o_Q;
  logic [n-1:0]   o_R;

  modport master (
    output start, i_A, i_B,
    input  stop, err, o_Q, o_R
  );

  modport slave (
    input  start, i_A, i_B,
    output stop, err, o_Q, o_R
  );

endinterface

// File: rtl/shiftsub_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module shiftsub_div_step #(
  parameter int n = 8
) (
  input  logic [n:0]   r_i,
  input  logic         d_i,
  input  logic [n-1:0] b_i,
  output logic [n:0]   r_next_o,
  output logic         q_bit_o
);

  // The partial remainder is always below the divisor, so r_i[n] is zero and
  // the shifted value fits n+1 bits; the extra top bit keeps the compare exact
  // for any input.
  logic [n+1:0] t;
  logic [n+1:0] b_ext;

  assign t     = {r_i, d_i};
  assign b_ext = {2'b00, b_i};

  // Compare, then either restore (keep t) or take the difference.
  always_comb begin
    q_bit_o  = (t >= b_ext);
    r_next_o = q_bit_o ? (n+1)'(t - b_ext) : (n+1)'(t);
  end

endmodule

// File: rtl/shiftsub_div.sv
// Sequential restoring divider: 2n-bit dividend / n-bit divisor, one quotient
// bit per clock, on the same start/stop handshake as the shift-add multiplier.
module shiftsub_div
  import shiftsub_div_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic           clk,
  input  logic           reset,
  shiftsub_div_if.slave  bus
);

  localparam int CW = cnt_width(n);

  state_t         state_q, state_d;
  logic [n:0]     r_q, r_d;
  logic [n-1:0]   qs_q, qs_d;
  logic [n-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           stop_q, stop_d;
  logic           err_q, err_d;
  logic [n-1:0]   quo_q, quo_d;
  logic [n-1:0]   rem_q, rem_d;

  logic [n:0]     step_r;
  logic           step_q;
  logic [n-1:0]   qs_shift;

  shiftsub_div_step #(.n(n)) u_step (
    .r_i      (r_q),
    .d_i      (qs_q[n-1]),
    .b_i      (b_q),
    .r_next_o (step_r),
    .q_bit_o  (step_q)
  );

  assign qs_shift = {qs_q[n-2:0], step_q};

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    r_d     = r_q;
    qs_d    = qs_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    err_d   = err_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          stop_d = 1'b0;
          err_d  = 1'b0;
          b_d    = bus.i_B;
          // High half not below the divisor means the quotient cannot fit
          // n bits; this also catches a zero divisor.
          if (bus.i_A[2*n-1:n] >= bus.i_B) begin
            state_d = DONE;
            stop_d  = 1'b1;
            err_d   = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
          end else begin
            state_d = RUN;
            r_d     = {1'b0, bus.i_A[2*n-1:n]};
            qs_d    = bus.i_A[n-1:0];
            cnt_d   = CW'(n);
          end
        end
      end

      RUN: begin
        r_d   = step_r;
        qs_d  = qs_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = qs_shift;
          rem_d   = step_r[n-1:0];
          stop_d  = 1'b1;
          err_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is reset as well, so an abandoned operation leaves nothing visible.
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      qs_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      r_q     <= r_d;
      qs_q    <= qs_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.stop = stop_q;
  assign bus.err  = err_q;
  assign bus.o_Q  = quo_q;
  assign bus.o_R  = rem_q;

endmodule

// File: tb/tb_shiftsub_div.sv
// Directed testbench for shiftsub_div (n=8).
module tb_shiftsub_div;
  import shiftsub_div_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  shiftsub_div_if #(.n(8)) bus ();

  shiftsub_div #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One rising edge, then return at the falling edge for driving and sampling.
  task automatic cycle(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic stop, input logic err,
                              input logic [7:0] q, input logic [7:0] r);
    check({tag, ".stop"}, 32'(bus.stop), 32'(stop));
    check({tag, ".err"},  32'(bus.err),  32'(err));
    check({tag, ".Q"},    32'(bus.o_Q),  32'(q));
    check({tag, ".R"},    32'(bus.o_R),  32'(r));
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    bus.i_A   = a;
    bus.i_B   = b;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0]  rb, rhi, rlo;
    logic [15:0] ra;

    reset     = 1'b0;
    bus.start = 1'b1;
    bus.i_A   = 16'd100;
    bus.i_B   = 8'd7;
    @(negedge clk);
    cycle(2);
    // Reset overrides start.
    check_result("reset", 1'b0, 1'b0, 8'd0, 8'd0);
    check("reset.state", 32'(dut.state_q), 32'(IDLE));
    bus.start = 1'b0;
    reset     = 1'b1;
    cycle();

    // 100 / 7: result after E0+8, inputs scrambled after acceptance.
    launch(16'd100, 8'd7);
    bus.i_A = 16'hFFFF;
    bus.i_B = 8'd1;
    check("t1.stop_after_E0", 32'(bus.stop), 32'd0);
    cycle(7);
    check("t1.stop_after_E7", 32'(bus.stop), 32'd0);
    cycle();
    check_result("t1.done", 1'b1, 1'b0, 8'd14, 8'd2);
    cycle(5);
    check_result("t1.hold", 1'b1, 1'b0, 8'd14, 8'd2);

    // 0xFE01 / 0xFF: high half just below divisor.
    launch(16'hFE01, 8'hFF);
    check("t2.stop_falls", 32'(bus.stop), 32'd0);
    check("t2.Q_holds", 32'(bus.o_Q), 32'd14);
    cycle(8);
    check_result("t2.done", 1'b1, 1'b0, 8'hFF, 8'h00);

    // Overflow: high half equal to divisor.
    launch(16'hFF00, 8'hFF);
    check_result("t3.ovf", 1'b1, 1'b1, 8'hFF, 8'h00);
    cycle(2);
    check_result("t3.ovf_hold", 1'b1, 1'b1, 8'hFF, 8'h00);
    // Divide by zero with a zero high half.
    launch(16'h0012, 8'h00);
    check_result("t3.div0", 1'b1, 1'b1, 8'hFF, 8'h00);

    // Start during RUN ignored, then reset abandons the operation.
    launch(16'd100, 8'd7);
    cycle(2);
    launch(16'd200, 8'd3);
    check("t4.stop_run", 32'(bus.stop), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_result("t4.reset", 1'b0, 1'b0, 8'd0, 8'd0);
    check("t4.state", 32'(dut.state_q), 32'(IDLE));
    cycle(10);
    check_result("t4.idle", 1'b0, 1'b0, 8'd0, 8'd0);
    launch(16'd200, 8'd3);
    cycle(8);
    check_result("t4.fresh", 1'b1, 1'b0, 8'd66, 8'd2);

    // start held high: 255 / 16 back to back, stop every 9th cycle.
    bus.i_A   = 16'd255;
    bus.i_B   = 8'd16;
    bus.start = 1'b1;
    for (int k = 0; k < 27; k++) begin
      cycle();
      if (k % 9 == 8) check_result("t5.pulse", 1'b1, 1'b0, 8'd15, 8'd15);
      else            check("t5.stop_low", 32'(bus.stop), 32'd0);
    end
    bus.start = 1'b0;
    cycle(9);

    // Random non-overflow sweep against A/B and A%B.
    for (int i = 0; i < 1000; i++) begin
      rb  = 8'($urandom_range(1, 255));
      rhi = 8'($urandom_range(0, int'(rb) - 1));
      rlo = 8'($urandom_range(0, 255));
      ra  = {rhi, rlo};
      launch(ra, rb);
      cycle(7);
      check("rnd.early", 32'(bus.stop), 32'd0);
      cycle();
      check_result("rnd", 1'b1, 1'b0, 8'(ra / 16'(rb)), 8'(ra % 16'(rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
